// File: rtl/rgmii_pkg.sv
`timescale 1ns/1ps
// Shared RGMII definitions: framing bytes, in-band speed codes and the receive FSM states.
package rgmii_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10
  } speed_e;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_e;

endpackage

// File: rtl/rgmii_rx_iddr.sv
`timescale 1ns/1ps
// Behavioural IDDR bank: each lane presents its rising and falling samples together
// on the rising edge that follows the falling sample.
module rgmii_rx_iddr
  import rgmii_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic rise_s;
    logic fall_s;
    logic q0_r;
    logic q1_r;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise_s <= 1'b0;
        q0_r   <= 1'b0;
        q1_r   <= 1'b0;
      end else begin
        rise_s <= d[i];
        q0_r   <= rise_s;
        q1_r   <= fall_s;
      end
    end

    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fall_s <= 1'b0;
      end else begin
        fall_s <= d[i];
      end
    end

    assign q0[i] = q0_r;
    assign q1[i] = q1_r;
  end

endmodule

// File: rtl/rgmii_rx.sv
`timescale 1ns/1ps
// RGMII receiver: DDR capture, preamble/SFD stripping and a valid/first/last/err byte stream.
// Define RGMII_RX_INBAND_STATUS_EN to decode in-band link status; otherwise status is fixed 1G full duplex.
module rgmii_rx
  import rgmii_pkg::*;
#(
  parameter int MAX_PREAMBLE = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rxd,
  input  logic       rx_ctl,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       dout_first,
  output logic       dout_last,
  output logic       dout_err,
  output logic       frame_drop,
  output logic       link_up,
  output logic [1:0] speed,
  output logic       full_duplex
);

  localparam int CW = $clog2(MAX_PREAMBLE + 1) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PREAMBLE);

  logic [4:0]    q0;
  logic [4:0]    q1;
  logic [7:0]    rx_byte;
  logic          rx_dv;
  logic          rx_er;
  rx_state_e     state;
  logic [CW-1:0] pre_cnt;
  logic          err_flag;
  logic [7:0]    hold;
  logic          hold_valid;
  logic          first_pend;

  rgmii_rx_iddr #(.WIDTH(5)) u_iddr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({rx_ctl, rxd}),
    .q0    (q0),
    .q1    (q1)
  );

  assign rx_byte = {q1[3:0], q0[3:0]};
  assign rx_dv   = q0[4];
  assign rx_er   = q0[4] ^ q1[4];

  // The hold register delays each byte by one beat so the end of frame can be flagged on the last byte itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      err_flag   <= 1'b0;
      hold       <= 8'h00;
      hold_valid <= 1'b0;
      first_pend <= 1'b0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      dout_err   <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      dout_err   <= 1'b0;
      frame_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_dv) begin
            if (rx_byte == PREAMBLE_BYTE) begin
              state   <= PREAMBLE;
              pre_cnt <= CW'(1);
            end else begin
              state      <= DROP;
              frame_drop <= 1'b1;
            end
          end
        end
        PREAMBLE: begin
          if (!rx_dv) begin
            state <= IDLE;
          end else if (rx_er) begin
            state      <= DROP;
            frame_drop <= 1'b1;
          end else if (rx_byte == PREAMBLE_BYTE) begin
            if (pre_cnt >= MAX_CNT) begin
              state      <= DROP;
              frame_drop <= 1'b1;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end else if (rx_byte == SFD_BYTE) begin
            state      <= DATA;
            err_flag   <= 1'b0;
            hold_valid <= 1'b0;
            first_pend <= 1'b1;
          end else begin
            state      <= DROP;
            frame_drop <= 1'b1;
          end
        end
        DATA: begin
          if (rx_dv) begin
            if (hold_valid) begin
              dout       <= hold;
              dout_valid <= 1'b1;
              dout_first <= first_pend;
              first_pend <= 1'b0;
            end
            hold       <= rx_byte;
            hold_valid <= 1'b1;
            if (rx_er) begin
              err_flag <= 1'b1;
            end
          end else begin
            if (hold_valid) begin
              dout       <= hold;
              dout_valid <= 1'b1;
              dout_first <= first_pend;
              dout_last  <= 1'b1;
              dout_err   <= err_flag;
            end else begin
              frame_drop <= 1'b1;
            end
            state      <= IDLE;
            hold_valid <= 1'b0;
            first_pend <= 1'b0;
          end
        end
        DROP: begin
          if (!rx_dv) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RGMII_RX_INBAND_STATUS_EN
  // Status is only trusted when the PHY repeats the same nibble on both edges of a clean idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_up     <= 1'b0;
      speed       <= SPEED_10;
      full_duplex <= 1'b0;
    end else if (!rx_dv && !rx_er && (q0[3:0] == q1[3:0])) begin
      link_up     <= q0[0];
      speed       <= q0[2:1];
      full_duplex <= q0[3];
    end
  end
`else
  assign link_up     = 1'b1;
  assign speed       = SPEED_1000;
  assign full_duplex = 1'b1;
`endif

endmodule

// File: tb/tb_rgmii_rx.sv
`timescale 1ns/1ps
// Self-checking bench for rgmii_rx: frames are built at byte level and compared against
// beat lists derived from the framing rules; honours RGMII_RX_INBAND_STATUS_EN.
module tb_rgmii_rx;
  import rgmii_pkg::*;

  localparam int PERIOD = 8;
  localparam int MAX_PRE = 15;
  localparam logic [7:0] QUIET = 8'h10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rxd = 4'h0;
  logic       rx_ctl = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, dout_first, dout_last, dout_err, frame_drop;
  logic       link_up, full_duplex;
  logic [1:0] speed;

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
    logic       err;
    time        t;
  } beat_t;

  beat_t      obs_q[$];
  beat_t      exp_q[$];
  logic [7:0] payload[$];
  int         drop_cnt;
  int         exp_drops;
  int         checks;
  int         errors;
  time        last_sample_t;
  time        pay_t;
  logic       exp_link;
  logic [1:0] exp_speed;
  logic       exp_fd;

  rgmii_rx #(.MAX_PREAMBLE(MAX_PRE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .rx_ctl      (rx_ctl),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_first  (dout_first),
    .dout_last   (dout_last),
    .dout_err    (dout_err),
    .frame_drop  (frame_drop),
    .link_up     (link_up),
    .speed       (speed),
    .full_duplex (full_duplex)
  );

  always #(PERIOD / 2) clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid) obs_q.push_back('{data: dout, first: dout_first, last: dout_last, err: dout_err, t: $time});
    if (frame_drop) drop_cnt++;
  end

  task automatic status_reset_values();
`ifdef RGMII_RX_INBAND_STATUS_EN
    exp_link = 1'b0; exp_speed = 2'b00; exp_fd = 1'b0;
`else
    exp_link = 1'b1; exp_speed = 2'b10; exp_fd = 1'b1;
`endif
  endtask

  // One wire byte: low nibble and dv before the rising edge, high nibble and dv^er before the falling edge.
  task automatic drive_byte(input logic [7:0] b, input logic dv, input logic er);
    rxd = b[3:0];
    rx_ctl = dv;
    @(posedge clk);
    last_sample_t = $time;
    #1;
    rxd = b[7:4];
    rx_ctl = dv ^ er;
    @(negedge clk);
    #1;
`ifdef RGMII_RX_INBAND_STATUS_EN
    if (rst_n && !dv && !er && b[3:0] == b[7:4]) begin
      exp_link = b[0]; exp_speed = b[2:1]; exp_fd = b[3];
    end
`endif
  endtask

  task automatic send_frame(input int npre, input int bad_at, input int err_pos);
    obs_q.delete();
    drop_cnt = 0;
    for (int i = 1; i <= npre; i++) drive_byte((i == bad_at) ? 8'hAA : 8'h55, 1'b1, 1'b0);
    drive_byte(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < payload.size(); i++) begin
      drive_byte(payload[i], 1'b1, i == err_pos);
      if (i == 0) pay_t = last_sample_t;
    end
    repeat (4) drive_byte(QUIET, 1'b0, 1'b0);
  endtask

  // Expected result of a frame from the framing rules alone.
  function automatic void model_frame(input int npre, input int bad_at, input int err_pos);
    int n;
    n = payload.size();
    exp_q.delete();
    exp_drops = 0;
    if (bad_at != 0 || npre > MAX_PRE || n == 0) begin
      exp_drops = 1;
    end else begin
      for (int i = 0; i < n; i++)
        exp_q.push_back('{data: payload[i], first: (i == 0), last: (i == n - 1),
                          err: (i == n - 1) && err_pos >= 0 && err_pos < n, t: 0});
    end
  endfunction

  task automatic test_reset();
    status_reset_values();
    #3;
    checks++;
    if ({dout, dout_valid, dout_first, dout_last, dout_err, frame_drop} !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {dout, dout_valid, dout_first, dout_last, dout_err, frame_drop});
    end
    checks++;
    if ({link_up, speed, full_duplex} !== {exp_link, exp_speed, exp_fd}) begin
      errors++;
      $display("[TB] FAIL reset_status: got %b expected %b", {link_up, speed, full_duplex}, {exp_link, exp_speed, exp_fd});
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) drive_byte(QUIET, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    payload.delete();
    for (int i = 1; i <= 64; i++) payload.push_back(8'(i));
    model_frame(7, 0, -1);
    send_frame(7, 0, -1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if ({obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].err} !==
            {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].err}) begin
          errors++;
          $display("[TB] FAIL basic_beat[%0d]: got %h/%b%b%b expected %h/%b%b%b", i, obs_q[i].data,
                   obs_q[i].first, obs_q[i].last, obs_q[i].err, exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].err);
        end
      end
      checks++;
      if (obs_q[0].t - pay_t != 3 * PERIOD + PERIOD / 2) begin
        errors++;
        $display("[TB] FAIL basic_latency: got %0t expected %0d", obs_q[0].t - pay_t, 3 * PERIOD + PERIOD / 2);
      end
      checks++;
      if (obs_q[63].t - obs_q[0].t != 63 * PERIOD) begin
        errors++;
        $display("[TB] FAIL basic_gapless: got span %0t expected %0d", obs_q[63].t - obs_q[0].t, 63 * PERIOD);
      end
    end
    checks++;
    if (drop_cnt != exp_drops) begin
      errors++;
      $display("[TB] FAIL basic_drops: got %0d expected %0d", drop_cnt, exp_drops);
    end
  endtask

  task automatic test_error();
    payload.delete();
    for (int i = 1; i <= 64; i++) payload.push_back(8'(i));
    model_frame(7, 0, 15);
    send_frame(7, 0, 15);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL error_count: got %0d beats expected %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if ({obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].err} !==
            {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].err}) begin
          errors++;
          $display("[TB] FAIL error_beat[%0d]: got %h/%b%b%b expected %h/%b%b%b", i, obs_q[i].data,
                   obs_q[i].first, obs_q[i].last, obs_q[i].err, exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].err);
        end
      end
    end
  endtask

  task automatic test_bad_preamble();
    payload.delete();
    for (int i = 0; i < 8; i++) payload.push_back(8'($urandom));
    model_frame(7, 3, -1);
    send_frame(7, 3, -1);
    checks++;
    if (obs_q.size() != 0 || drop_cnt != exp_drops) begin
      errors++;
      $display("[TB] FAIL bad_preamble: got %0d beats %0d drops expected 0 beats %0d drops", obs_q.size(), drop_cnt, exp_drops);
    end
    payload.delete();
    for (int i = 0; i < 12; i++) payload.push_back(8'($urandom));
    model_frame(4, 0, -1);
    send_frame(4, 0, -1);
    checks++;
    if (obs_q.size() != exp_q.size() || drop_cnt != exp_drops) begin
      errors++;
      $display("[TB] FAIL after_drop_count: got %0d beats %0d drops expected %0d beats %0d drops",
               obs_q.size(), drop_cnt, exp_q.size(), exp_drops);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if ({obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].err} !==
            {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].err}) begin
          errors++;
          $display("[TB] FAIL after_drop_beat[%0d]: got %h expected %h", i, obs_q[i].data, exp_q[i].data);
        end
      end
    end
  endtask

  task automatic test_short_frames();
    payload.delete();
    model_frame(3, 0, -1);
    send_frame(3, 0, -1);
    checks++;
    if (obs_q.size() != 0 || drop_cnt != exp_drops) begin
      errors++;
      $display("[TB] FAIL zero_byte: got %0d beats %0d drops expected 0 beats %0d drops", obs_q.size(), drop_cnt, exp_drops);
    end
    payload.delete();
    payload.push_back(8'h7E);
    model_frame(1, 0, -1);
    send_frame(1, 0, -1);
    checks++;
    if (obs_q.size() != 1 || drop_cnt != 0) begin
      errors++;
      $display("[TB] FAIL one_byte_count: got %0d beats %0d drops expected 1 beat 0 drops", obs_q.size(), drop_cnt);
    end else if ({obs_q[0].data, obs_q[0].first, obs_q[0].last, obs_q[0].err} !==
                 {exp_q[0].data, exp_q[0].first, exp_q[0].last, exp_q[0].err}) begin
      errors++;
      $display("[TB] FAIL one_byte_beat: got %h/%b%b%b expected %h/%b%b%b", obs_q[0].data, obs_q[0].first,
               obs_q[0].last, obs_q[0].err, exp_q[0].data, exp_q[0].first, exp_q[0].last, exp_q[0].err);
    end
  endtask

  task automatic test_preamble_limit();
    for (int npre = MAX_PRE; npre <= MAX_PRE + 1; npre++) begin
      payload.delete();
      for (int i = 0; i < 5; i++) payload.push_back(8'($urandom));
      model_frame(npre, 0, -1);
      send_frame(npre, 0, -1);
      checks++;
      if (obs_q.size() != exp_q.size() || drop_cnt != exp_drops) begin
        errors++;
        $display("[TB] FAIL preamble_limit_%0d: got %0d beats %0d drops expected %0d beats %0d drops",
                 npre, obs_q.size(), drop_cnt, exp_q.size(), exp_drops);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (obs_q[i].data !== exp_q[i].data) begin
            errors++;
            $display("[TB] FAIL preamble_limit_beat[%0d]: got %h expected %h", i, obs_q[i].data, exp_q[i].data);
          end
        end
      end
    end
  endtask

  task automatic test_status();
    logic [3:0] old_s;
    repeat (3) drive_byte(8'h00, 1'b0, 1'b0);
    old_s = {exp_link, exp_speed, exp_fd};
    drive_byte(8'hDD, 1'b0, 1'b0);
    drive_byte(QUIET, 1'b0, 1'b0);
    checks++;
    if ({link_up, speed, full_duplex} !== old_s) begin
      errors++;
      $display("[TB] FAIL status_early: got %b expected %b", {link_up, speed, full_duplex}, old_s);
    end
    drive_byte(QUIET, 1'b0, 1'b0);
    checks++;
    if ({link_up, speed, full_duplex} !== {exp_link, exp_speed, exp_fd}) begin
      errors++;
      $display("[TB] FAIL status_dd: got %b expected %b", {link_up, speed, full_duplex}, {exp_link, exp_speed, exp_fd});
    end
    repeat (3) drive_byte(8'h3D, 1'b0, 1'b0);
    repeat (3) drive_byte(8'h22, 1'b0, 1'b1);
    checks++;
    if ({link_up, speed, full_duplex} !== {exp_link, exp_speed, exp_fd}) begin
      errors++;
      $display("[TB] FAIL status_hold: got %b expected %b", {link_up, speed, full_duplex}, {exp_link, exp_speed, exp_fd});
    end
    repeat (3) drive_byte(8'h22, 1'b0, 1'b0);
    checks++;
    if ({link_up, speed, full_duplex} !== {exp_link, exp_speed, exp_fd}) begin
      errors++;
      $display("[TB] FAIL status_22: got %b expected %b", {link_up, speed, full_duplex}, {exp_link, exp_speed, exp_fd});
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    payload.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      payload.push_back((b == 8'h55) ? 8'h56 : b);
    end
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b1, 1'b0);
    drive_byte(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive_byte(payload[i], 1'b1, 1'b0);
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_frame_valid: got %b expected 1", dout_valid);
    end
    rst_n = 1'b0;
    status_reset_values();
    #1;
    checks++;
    if ({dout, dout_valid, dout_first, dout_last, dout_err, frame_drop} !== 13'h0 ||
        {link_up, speed, full_duplex} !== {exp_link, exp_speed, exp_fd}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h/%b expected 0/%b", {dout, dout_valid, dout_first, dout_last, dout_err, frame_drop},
               {link_up, speed, full_duplex}, {exp_link, exp_speed, exp_fd});
    end
    obs_q.delete();
    drop_cnt = 0;
    for (int i = 8; i < 10; i++) drive_byte(payload[i], 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 10; i < 16; i++) drive_byte(payload[i], 1'b1, 1'b0);
    repeat (4) drive_byte(QUIET, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 0 || drop_cnt != 1) begin
      errors++;
      $display("[TB] FAIL post_reset_drop: got %0d beats %0d drops expected 0 beats 1 drop", obs_q.size(), drop_cnt);
    end
    payload.delete();
    for (int i = 0; i < 10; i++) payload.push_back(8'($urandom));
    model_frame(5, 0, -1);
    send_frame(5, 0, -1);
    checks++;
    if (obs_q.size() != exp_q.size() || drop_cnt != exp_drops) begin
      errors++;
      $display("[TB] FAIL post_reset_frame: got %0d beats %0d drops expected %0d beats %0d drops",
               obs_q.size(), drop_cnt, exp_q.size(), exp_drops);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if ({obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].err} !==
            {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].err}) begin
          errors++;
          $display("[TB] FAIL post_reset_beat[%0d]: got %h expected %h", i, obs_q[i].data, exp_q[i].data);
        end
      end
    end
  endtask

  task automatic test_random();
    int kind, len, npre, bad_at, err_pos;
    logic [3:0] nib;
    logic [7:0] idle_b;
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 3; k++) begin
        nib = 4'($urandom);
        idle_b = ($urandom_range(0, 1) == 1) ? {nib, nib} : 8'($urandom);
        drive_byte(idle_b, 1'b0, $urandom_range(0, 3) == 0);
      end
      kind = $urandom_range(0, 5);
      len = (kind == 3) ? 0 : $urandom_range(1, 20);
      npre = (kind == 4) ? MAX_PRE + 1 + $urandom_range(0, 2) : (kind == 5) ? MAX_PRE : $urandom_range(1, MAX_PRE);
      bad_at = (kind == 2) ? $urandom_range(1, npre) : 0;
      err_pos = (kind == 1) ? $urandom_range(0, len - 1) : -1;
      payload.delete();
      for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
      model_frame(npre, bad_at, err_pos);
      send_frame(npre, bad_at, err_pos);
      checks++;
      if (obs_q.size() != exp_q.size() || drop_cnt != exp_drops) begin
        errors++;
        $display("[TB] FAIL random_%0d_kind%0d: got %0d beats %0d drops expected %0d beats %0d drops",
                 f, kind, obs_q.size(), drop_cnt, exp_q.size(), exp_drops);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if ({obs_q[i].data, obs_q[i].first, obs_q[i].last, obs_q[i].err} !==
              {exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].err}) begin
            errors++;
            $display("[TB] FAIL random_%0d_beat[%0d]: got %h/%b%b%b expected %h/%b%b%b", f, i, obs_q[i].data,
                     obs_q[i].first, obs_q[i].last, obs_q[i].err, exp_q[i].data, exp_q[i].first, exp_q[i].last, exp_q[i].err);
          end
        end
      end
      checks++;
      if ({link_up, speed, full_duplex} !== {exp_link, exp_speed, exp_fd}) begin
        errors++;
        $display("[TB] FAIL random_%0d_status: got %b expected %b", f, {link_up, speed, full_duplex}, {exp_link, exp_speed, exp_fd});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drop_cnt = 0;
    test_reset();
    test_basic();
    test_error();
    test_bad_preamble();
    test_short_frames();
    test_preamble_limit();
    test_status();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
